tiny8_control: RTL and testbench
================================

Name: tiny8_control

Overview:
- Multicycle control FSM for the tiny8 core; sits directly upstream of the datapath and drives every load, mux select and aluop it consumes.
- Sequences fetch/execute/memory phases from the decoded IR fields.
- Owns the memory request handshake (mem_read/mem_write/mem_resp).
- Purely control: no data words pass through it.

Parameters:
- None. Widths are fixed by the tiny8 types: 8-bit word, 3-bit opcode, 3-bit aluop.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- opcode  input  3  IR opcode field, valid from the cycle after load_ir
- br_en  input  1  branch condition from datapath, sampled in EXEC
- mem_resp  input  1  memory completes the current read/write this cycle
- load_pc, load_ir, load_acc, load_rs, load_rd  output  1 each  datapath register loads
- aluop  output  3  tiny8_aluop encoding: 000 add, 001 sub, 010 and
- pcmux_sel  output  1  0 = pc+1, 1 = pc+imm4
- addrmux_sel  output  2  00 = pc, 01 = rs, 10 = rd
- alumux1_sel  output  1  0 = rs, 1 = rd
- alumux2_sel  output  1  0 = delta2, 1 = imm4
- regfilemux_sel  output  1  0 = alu_out, 1 = mem_rdata
- mem_read, mem_write  output  1 each  memory request strobes, level-held until mem_resp
- halted  output  1  high while in HALTED

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state register goes to FETCH at the next edge. While rst is high, all outputs are forced to 0 in that cycle.
- Default output value is 0 for every signal not listed in a state.
- Opcode map:
  - 000 ADDI: rd += imm4
  - 001 SUBI: rd -= imm4
  - 010 ANDI: rd &= imm4
  - 011 ACC: acc += rs+delta2
  - 100 LD: rd = M[rs]; rs += delta2
  - 101 ST: M[rs] = rd; rs += delta2
  - 110 BRZ: if br_en then pc += imm4, else pc += 1
  - 111 HALT
- FETCH:
  - Asserts addrmux_sel=00, mem_read=1, and load_ir=mem_resp.
  - On mem_resp, go to EXEC; otherwise stay. Wait time is unbounded.
- EXEC (exactly 1 cycle). Asserts load_pc=1 for every opcode except HALT, with pcmux_sel=0 except for taken BRZ.
  - ADDI/SUBI/ANDI: alumux1_sel=1, alumux2_sel=1, aluop add/sub/and, regfilemux_sel=0, load_rd=1. Next state FETCH.
  - ACC: alumux1_sel=0, alumux2_sel=0, aluop=add, load_acc=1. Next state FETCH.
  - BRZ: pcmux_sel=br_en. Next state FETCH.
  - LD/ST: next state MEM. PC is incremented here, before the memory access.
  - HALT: next state HALTED, no loads.
- MEM:
  - Asserts addrmux_sel=01, plus mem_read (LD) or mem_write (ST), held every cycle until mem_resp.
  - In the mem_resp cycle:
    - load_rs=1 with alumux1_sel=0, alumux2_sel=0, aluop=add.
    - LD only: additionally load_rd=1 with regfilemux_sel=1.
    - Next state FETCH.
  - Without mem_resp: stay in MEM with no loads.
- HALTED: halted=1, all other outputs 0. Leaves HALTED only via rst.
- Simultaneous events:
  - rst together with mem_resp: rst wins; no load is asserted and the state goes to FETCH.
  - mem_resp outside FETCH/MEM is ignored.
- Register loads of 8-bit values wrap modulo 256; that arithmetic is in the datapath, and control makes no width decisions.
- mem_read and mem_write are never high in the same cycle.

Optional Feature:
- Macro: TINY8_CTRL_PERF_EN.
- When defined, adds two outputs:
  - cycle_count [15:0]: increments every non-reset cycle while not HALTED.
  - instr_count [15:0]: increments on each EXEC cycle.
- Both counters clear on rst and wrap 0xFFFF→0x0000.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Fetch latency: rst 1 cycle, mem_resp low 3 cycles then high → mem_read high 4 cycles, load_ir=1 only on the 4th, EXEC on the 5th.
- ADDI (opcode 000) in EXEC → load_rd=1, aluop=000, alumux1_sel=1, alumux2_sel=1, load_pc=1, pcmux_sel=0; FETCH next cycle.
- LD (100), mem_resp after 2 MEM cycles → addrmux_sel=01, mem_read held 2 cycles. Resp cycle: load_rd=1, regfilemux_sel=1, load_rs=1, aluop=000.
- BRZ (110): br_en=1 → pcmux_sel=1, load_pc=1. br_en=0 → pcmux_sel=0.
- HALT (111) → halted=1 and all outputs 0 for 10 cycles despite mem_resp toggling; rst → FETCH with mem_read=1 the cycle after reset deasserts.
- Reset mid-ST: rst in MEM with mem_resp=1 → mem_write=0, load_rs=0 that cycle, then FETCH. With TINY8_CTRL_PERF_EN: counters read 0 after rst; instr_count=3 after three instructions.

Source files
------------

// File: rtl/tiny8_control.sv
// tiny8_control: multicycle control FSM for the tiny8 core.
//
// Sequences FETCH -> EXEC -> (MEM) -> FETCH from the IR opcode field and
// drives every datapath register load and mux select. Owns the memory
// request handshake; no data words pass through this block.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   opcode[2:0]         IR opcode, valid from the cycle after load_ir
//   br_en               branch condition, sampled in EXEC
//   mem_resp            memory completes the current request this cycle
//   load_pc/ir/acc/rs/rd  datapath register loads
//   aluop[2:0]          000 add, 001 sub, 010 and
//   pcmux_sel           0 = pc+1, 1 = pc+imm4
//   addrmux_sel[1:0]    00 = pc, 01 = rs, 10 = rd
//   alumux1_sel         0 = rs, 1 = rd
//   alumux2_sel         0 = delta2, 1 = imm4
//   regfilemux_sel      0 = alu_out, 1 = mem_rdata
//   mem_read, mem_write level-held request strobes until mem_resp
//   halted              high while in HALTED
//
// Optional feature (macro TINY8_CTRL_PERF_EN): adds cycle_count[15:0]
// (non-reset, non-halted cycles) and instr_count[15:0] (EXEC cycles).
module tiny8_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       br_en,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_acc,
  output logic       load_rs,
  output logic       load_rd,
  output logic [2:0] aluop,
  output logic       pcmux_sel,
  output logic [1:0] addrmux_sel,
  output logic       alumux1_sel,
  output logic       alumux2_sel,
  output logic       regfilemux_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       halted
`ifdef TINY8_CTRL_PERF_EN
  ,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
`endif
);

  localparam logic [2:0] OpAddi = 3'b000;
  localparam logic [2:0] OpSubi = 3'b001;
  localparam logic [2:0] OpAndi = 3'b010;
  localparam logic [2:0] OpAcc  = 3'b011;
  localparam logic [2:0] OpLd   = 3'b100;
  localparam logic [2:0] OpSt   = 3'b101;
  localparam logic [2:0] OpBrz  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  localparam logic [2:0] AluAdd = 3'b000;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalted} state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_acc       = 1'b0;
    load_rs        = 1'b0;
    load_rd        = 1'b0;
    aluop          = AluAdd;
    pcmux_sel      = 1'b0;
    addrmux_sel    = 2'b00;
    alumux1_sel    = 1'b0;
    alumux2_sel    = 1'b0;
    regfilemux_sel = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    halted         = 1'b0;

    // Reset masks every output, including a coincident mem_resp.
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_read = 1'b1;
          load_ir  = mem_resp;
          if (mem_resp) state_d = StFetch == StFetch ? StExec : StFetch;
        end
        StExec: begin
          load_pc = (opcode != OpHalt);
          state_d = StFetch;
          unique case (opcode)
            OpAddi, OpSubi, OpAndi: begin
              // Opcode encoding of the immediate ops matches the aluop encoding.
              alumux1_sel = 1'b1;
              alumux2_sel = 1'b1;
              aluop       = opcode;
              load_rd     = 1'b1;
            end
            OpAcc:        load_acc  = 1'b1;
            OpBrz:        pcmux_sel = br_en;
            OpLd, OpSt:   state_d   = StMem;
            OpHalt:       state_d   = StHalted;
            default:      state_d   = StFetch;
          endcase
        end
        StMem: begin
          addrmux_sel = 2'b01;
          mem_read    = (opcode == OpLd);
          mem_write   = (opcode == OpSt);
          if (mem_resp) begin
            // rs post-increment by delta2 shares the resp cycle with the access.
            load_rs = 1'b1;
            if (opcode == OpLd) begin
              load_rd        = 1'b1;
              regfilemux_sel = 1'b1;
            end
            state_d = StFetch;
          end
        end
        StHalted: halted = 1'b1;
        default:  state_d = StFetch;
      endcase
    end
  end

`ifdef TINY8_CTRL_PERF_EN
  logic [15:0] cycle_count_q, instr_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= 16'h0000;
      instr_count_q <= 16'h0000;
    end else begin
      if (state_q != StHalted) cycle_count_q <= cycle_count_q + 16'd1;
      if (state_q == StExec)   instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_tiny8_control.sv
// Self-checking bench for tiny8_control: directed test-plan steps followed by
// randomized opcode / handshake traffic, all compared every cycle against a
// phase-level reference model of the instruction sequencing rules.
module tb_tiny8_control;

  logic       clk, rst;
  logic [2:0] opcode;
  logic       br_en, mem_resp;
  logic       load_pc, load_ir, load_acc, load_rs, load_rd;
  logic [2:0] aluop;
  logic       pcmux_sel;
  logic [1:0] addrmux_sel;
  logic       alumux1_sel, alumux2_sel, regfilemux_sel;
  logic       mem_read, mem_write, halted;
`ifdef TINY8_CTRL_PERF_EN
  logic [15:0] cycle_count, instr_count;
`endif

  tiny8_control dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .br_en          (br_en),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_acc       (load_acc),
    .load_rs        (load_rs),
    .load_rd        (load_rd),
    .aluop          (aluop),
    .pcmux_sel      (pcmux_sel),
    .addrmux_sel    (addrmux_sel),
    .alumux1_sel    (alumux1_sel),
    .alumux2_sel    (alumux2_sel),
    .regfilemux_sel (regfilemux_sel),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .halted         (halted)
`ifdef TINY8_CTRL_PERF_EN
    ,
    .cycle_count    (cycle_count),
    .instr_count    (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every control output, in a fixed order.
  logic [16:0] obs;
  assign obs = {load_pc, load_ir, load_acc, load_rs, load_rd, aluop, pcmux_sel, addrmux_sel,
                alumux1_sel, alumux2_sel, regfilemux_sel, mem_read, mem_write, halted};

  typedef enum int {PhFetch, PhExec, PhMem, PhHalted} phase_t;
  phase_t      ph = PhFetch;
  logic [15:0] cyc_m = 16'h0, ins_m = 16'h0;
  int          checks = 0;
  int          errors = 0;

  // Expected outputs from the instruction semantics of the current phase.
  function automatic logic [16:0] model_out();
    logic lpc, lir, lacc, lrs, lrd, pcm, a1, a2, rfm, mr, mw, h;
    logic [2:0] alu;
    logic [1:0] am;
    {lpc, lir, lacc, lrs, lrd, pcm, a1, a2, rfm, mr, mw, h} = '0;
    alu = 3'b000;
    am  = 2'b00;
    if (!rst) begin
      case (ph)
        PhFetch: begin
          mr  = 1'b1;
          lir = mem_resp;
        end
        PhExec: begin
          lpc = (opcode != 3'd7);
          if (opcode <= 3'd2) begin
            a1 = 1'b1; a2 = 1'b1; lrd = 1'b1;
            alu = (opcode == 3'd0) ? 3'b000 : (opcode == 3'd1) ? 3'b001 : 3'b010;
          end
          if (opcode == 3'd3) lacc = 1'b1;
          if (opcode == 3'd6) pcm = br_en;
        end
        PhMem: begin
          am = 2'b01;
          mr = (opcode == 3'd4);
          mw = (opcode == 3'd5);
          if (mem_resp) begin
            lrs = 1'b1;
            if (opcode == 3'd4) begin
              lrd = 1'b1; rfm = 1'b1;
            end
          end
        end
        default: h = 1'b1;
      endcase
    end
    return {lpc, lir, lacc, lrs, lrd, alu, pcm, am, a1, a2, rfm, mr, mw, h};
  endfunction

  task automatic advance();
`ifdef TINY8_CTRL_PERF_EN
    if (rst) begin
      cyc_m = 16'h0; ins_m = 16'h0;
    end else begin
      if (ph != PhHalted) cyc_m = cyc_m + 16'd1;
      if (ph == PhExec)   ins_m = ins_m + 16'd1;
    end
`endif
    if (rst) ph = PhFetch;
    else begin
      case (ph)
        PhFetch: if (mem_resp) ph = PhExec;
        PhExec:  ph = (opcode == 3'd7) ? PhHalted :
                      (opcode == 3'd4 || opcode == 3'd5) ? PhMem : PhFetch;
        PhMem:   if (mem_resp) ph = PhFetch;
        default: ph = PhHalted;
      endcase
    end
  endtask

  // Check outputs mid-cycle with the current inputs, then let one edge pass.
  task automatic tick(input string tag);
    logic [16:0] exp;
    @(negedge clk);
    exp = model_out();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs observed=%05h expected=%05h", tag, obs, exp);
    end
`ifdef TINY8_CTRL_PERF_EN
    checks++;
    assert (cycle_count === cyc_m) else begin
      errors++;
      $error("FAIL %s cycle_count: observed=%0d expected=%0d", tag, cycle_count, cyc_m);
    end
    checks++;
    assert (instr_count === ins_m) else begin
      errors++;
      $error("FAIL %s instr_count: observed=%0d expected=%0d", tag, instr_count, ins_m);
    end
`endif
    @(posedge clk);
    #1;
    advance();
  endtask

  // One-cycle fetch followed by the EXEC cycle of op.
  task automatic run_op(input logic [2:0] op, input logic br, input string tag);
    opcode = op; br_en = br; mem_resp = 1'b1;
    tick({tag, "_fetch"});
    mem_resp = 1'b0;
    tick({tag, "_exec"});
  endtask

  initial begin
    rst = 1'b1; opcode = 3'd0; br_en = 1'b0; mem_resp = 1'b0;
    tick("reset");

    rst = 1'b0;
    repeat (3) tick("fetch_wait");
    mem_resp = 1'b1;
    tick("fetch_resp");
    mem_resp = 1'b0;
    tick("addi_exec");

    run_op(3'd4, 1'b0, "ld");
    tick("ld_mem_wait");
    mem_resp = 1'b1;
    tick("ld_mem_resp");

    run_op(3'd6, 1'b1, "brz_taken");
    run_op(3'd6, 1'b0, "brz_not_taken");
    run_op(3'd3, 1'b0, "acc");
    run_op(3'd2, 1'b0, "andi");

    run_op(3'd7, 1'b0, "halt");
    for (int i = 0; i < 10; i++) begin
      mem_resp = i[0];
      tick("halted_hold");
    end
    rst = 1'b1; mem_resp = 1'b1;
    tick("rst_in_halted");
    rst = 1'b0; mem_resp = 1'b0;
    tick("fetch_after_rst");

    run_op(3'd5, 1'b0, "st");
    tick("st_mem_wait");
    rst = 1'b1; mem_resp = 1'b1;
    tick("rst_mid_st");
    rst = 1'b0; mem_resp = 1'b0;
    tick("fetch_after_st_rst");

    run_op(3'd0, 1'b0, "perf_i1");
    run_op(3'd3, 1'b0, "perf_i2");
    run_op(3'd1, 1'b0, "perf_i3");
`ifdef TINY8_CTRL_PERF_EN
    checks++;
    assert (instr_count === 16'd3) else begin
      errors++;
      $error("FAIL instr_count_three: observed=%0d expected=3", instr_count);
    end
`endif

    for (int i = 0; i < 600; i++) begin
      rst      = (ph == PhHalted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 49) == 0);
      if (ph == PhFetch) opcode = 3'($urandom);
      br_en    = 1'($urandom);
      mem_resp = ($urandom_range(0, 2) == 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
